idex_operand_stage: RTL and testbench
=====================================

// Module: idex_operand_stage
// PURPOSE
//  ID/EX pipeline register directly upstream of the ALU. Captures decoded operands and control, and resolves
//  forwarding from EX/MEM and MEM/WB. Drives ALU op1/op2/ctrl. Detects load-use hazards and inserts one bubble.
//  Valid/ready handshake on both sides; flush support for branches.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  ADDR_WIDTH  5   register index width
// PORTS
//  clk               in   1           clock, rising edge
//  rst_n             in   1           asynchronous active-low reset
//  in_valid_i        in   1           decode beat valid
//  in_ready_o        out  1           stage accepts beat this cycle
//  rs1_data_i        in   DATA_WIDTH  regfile read 1
//  rs2_data_i        in   DATA_WIDTH  regfile read 2
//  imm_i             in   DATA_WIDTH  sign-extended immediate
//  pc_i              in   DATA_WIDTH  instruction PC
//  rs1_addr_i        in   ADDR_WIDTH  source 1 index
//  rs2_addr_i        in   ADDR_WIDTH  source 2 index
//  rd_addr_i         in   ADDR_WIDTH  destination index
//  alu_ctrl_i        in   3           0 ADD,1 SUB,2 AND,3 OR,4 SLT,5 LSHIFT
//  alusrc_a_i        in   1           1: op1=PC, 0: op1=rs1
//  alusrc_b_i        in   1           1: op2=imm, 0: op2=rs2
//  reg_write_i       in   1           writes rd
//  mem_read_i        in   1           load instruction
//  mem_write_i       in   1           store instruction
//  flush_i           in   1           kill held instr and accepted beat
//  exmem_rd_i        in   ADDR_WIDTH  EX/MEM dest
//  exmem_regwrite_i  in   1           EX/MEM writes rd
//  exmem_result_i    in   DATA_WIDTH  EX/MEM ALU result
//  memwb_rd_i        in   ADDR_WIDTH  MEM/WB dest
//  memwb_regwrite_i  in   1           MEM/WB writes rd
//  memwb_result_i    in   DATA_WIDTH  MEM/WB writeback value
//  out_ready_i       in   1           ALU/EX stage accepts
//  out_valid_o       out  1           held instruction valid
//  alu_op1_o         out  DATA_WIDTH  ALU operand 1
//  alu_op2_o         out  DATA_WIDTH  ALU operand 2
//  alu_ctrl_o        out  3           ALU function
//  store_data_o      out  DATA_WIDTH  forwarded rs2 for stores
//  pc_o, rd_addr_o   out  DATA_WIDTH, ADDR_WIDTH  pass-through
//  reg_write_o, mem_read_o, mem_write_o  out  1   control, ANDed with out_valid_o
// BEHAVIOUR
//  Reset: out_valid_o=0; all registered fields=0, so every output=0 (ALU sees ADD 0+0).
//  Latency: 1 cycle; beat accepted at edge N is presented from N+1.
//  hazard = out_valid_o & mem_read_o & rd_addr_o!=0 & (rd_addr_o==rs1_addr_i | rd_addr_o==rs2_addr_i).
//    Compared regardless of alusrc.
//  in_ready_o = (!out_valid_o | out_ready_i) & !hazard. fire = in_valid_i & in_ready_o.
//  Edge: flush_i -> out_valid<=0, beat discarded even if fire; else fire -> load, out_valid<=1;
//    else out_ready_i -> out_valid<=0 (bubble, incl. load-use); else hold.
//  Forwarding, combinational on registered rs data per source s:
//    s_addr!=0 & exmem_regwrite & exmem_rd==s_addr -> exmem_result;
//    else likewise MEM/WB -> memwb_result; else registered data. EX/MEM wins; x0 never forwarded.
//  Hold refresh: out_valid_o & !out_ready_i & !flush_i -> registered rs1/rs2 data <= forwarded values.
//    Keeps a producer leaving MEM/WB during a stall from being lost.
//  alu_op1_o = alusrc_a ? pc : fwd_rs1; alu_op2_o = alusrc_b ? imm : fwd_rs2; store_data_o = fwd_rs2.
//  No arithmetic in this block; widths are pass-through; alu_ctrl values 6,7 pass unchanged.
//  Async reset mid-stall clears valid immediately; no partial state survives.
// TESTING
//  Reset asserted mid-stream -> all outputs 0, out_valid_o=0 same cycle; first beat after release appears next cycle.
//  ADD x3,x1,x2, rs1=5, rs2=7, exmem_rd=1 result=100, memwb_rd=1 result=50 -> op1=100, op2=7 (EX/MEM priority).
//  Held LW rd=4, next beat rs1=4 -> in_ready_o=0 one cycle, bubble out (valid=0), then beat accepted.
//  out_ready_i=0 for 3 cycles, rs2=2 forwarded from MEM/WB 0xAB then producer gone -> op2 stays 0xAB; no re-accept.
//  exmem_rd=0 regwrite=1 result=0xFFFF, rs1_addr=0 rs1=0 -> op1=0.
//  flush_i with in_valid_i=1 -> next cycle out_valid_o=0, reg_write_o=mem_write_o=0.

Source files
------------

// File: rtl/idex_operand_stage.sv
// ID/EX operand stage: one-deep pipeline register ahead of the ALU.
// Captures a decoded beat, resolves EX/MEM and MEM/WB forwarding on the held
// source operands, and stalls for one cycle on a load-use dependency.

// Forwarding mux for one source operand. EX/MEM has priority over MEM/WB,
// and x0 is never forwarded because it is hard-wired to zero.
module idex_fwd_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] src_addr_i,
  input  logic [DATA_WIDTH-1:0] reg_data_i,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                  exmem_regwrite_i,
  input  logic [DATA_WIDTH-1:0] exmem_result_i,
  input  logic [ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                  memwb_regwrite_i,
  input  logic [DATA_WIDTH-1:0] memwb_result_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o
);
  logic src_nz;
  assign src_nz = (src_addr_i != '0);

  // Pick the youngest in-flight producer of this source, else the regfile value.
  always_comb begin
    fwd_data_o = reg_data_i;
    if (src_nz && exmem_regwrite_i && (exmem_rd_i == src_addr_i))
      fwd_data_o = exmem_result_i;
    else if (src_nz && memwb_regwrite_i && (memwb_rd_i == src_addr_i))
      fwd_data_o = memwb_result_i;
  end
endmodule

module idex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [2:0]            alu_ctrl_i,
  input  logic                  alusrc_a_i,
  input  logic                  alusrc_b_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  flush_i,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic                  exmem_regwrite_i,
  input  logic [DATA_WIDTH-1:0] exmem_result_i,
  input  logic [ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic                  memwb_regwrite_i,
  input  logic [DATA_WIDTH-1:0] memwb_result_i,
  input  logic                  out_ready_i,
  output logic                  out_valid_o,
  output logic [DATA_WIDTH-1:0] alu_op1_o,
  output logic [DATA_WIDTH-1:0] alu_op2_o,
  output logic [2:0]            alu_ctrl_o,
  output logic [DATA_WIDTH-1:0] store_data_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o
);
  localparam int NUM_SRC = 2;  // index 0 = rs1, 1 = rs2

  // Non-operand fields of a held instruction.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic [ADDR_WIDTH-1:0] rd;
    logic [2:0]            ctrl;
    logic                  src_a;
    logic                  src_b;
    logic                  rw;
    logic                  mr;
    logic                  mw;
  } idex_beat_t;

  logic                                 valid_q, valid_d;
  idex_beat_t                           beat_q, beat_d;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   rs_data_q, rs_data_d;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   rs_addr_q, rs_addr_d;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   rs_data_in;
  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0]   rs_addr_in;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]   fwd_data;
  idex_beat_t                           beat_in;
  logic                                 hazard;
  logic                                 fire;

  assign rs_data_in = {rs2_data_i, rs1_data_i};
  assign rs_addr_in = {rs2_addr_i, rs1_addr_i};

  assign beat_in = '{pc: pc_i, imm: imm_i, rd: rd_addr_i, ctrl: alu_ctrl_i,
                     src_a: alusrc_a_i, src_b: alusrc_b_i,
                     rw: reg_write_i, mr: mem_read_i, mw: mem_write_i};

  // Load-use: the held load's data is not ready for the incoming beat yet.
  // Both sources are compared even if the ALU ignores one, keeping the check cheap.
  assign hazard = valid_q && beat_q.mr && (beat_q.rd != '0) &&
                  ((beat_q.rd == rs1_addr_i) || (beat_q.rd == rs2_addr_i));

  assign in_ready_o = (!valid_q || out_ready_i) && !hazard;
  assign fire       = in_valid_i && in_ready_o;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
    idex_fwd_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd (
      .src_addr_i       (rs_addr_q[gi]),
      .reg_data_i       (rs_data_q[gi]),
      .exmem_rd_i       (exmem_rd_i),
      .exmem_regwrite_i (exmem_regwrite_i),
      .exmem_result_i   (exmem_result_i),
      .memwb_rd_i       (memwb_rd_i),
      .memwb_regwrite_i (memwb_regwrite_i),
      .memwb_result_i   (memwb_result_i),
      .fwd_data_o       (fwd_data[gi])
    );
  end

  // Next-state: flush beats everything, then accept, then drain, else hold.
  // While stalled, operands absorb forwarded values so a producer that retires
  // out of MEM/WB during the stall is not lost.
  always_comb begin
    valid_d   = valid_q;
    beat_d    = beat_q;
    rs_data_d = rs_data_q;
    rs_addr_d = rs_addr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (fire) begin
      valid_d   = 1'b1;
      beat_d    = beat_in;
      rs_data_d = rs_data_in;
      rs_addr_d = rs_addr_in;
    end else if (out_ready_i) begin
      valid_d = 1'b0;
    end else if (valid_q) begin
      rs_data_d = fwd_data;
    end
  end

  // Pipeline register; async reset clears valid and every captured field.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      beat_q    <= '0;
      rs_data_q <= '0;
      rs_addr_q <= '0;
    end else begin
      valid_q   <= valid_d;
      beat_q    <= beat_d;
      rs_data_q <= rs_data_d;
      rs_addr_q <= rs_addr_d;
    end
  end

  assign out_valid_o  = valid_q;
  assign alu_op1_o    = beat_q.src_a ? beat_q.pc  : fwd_data[0];
  assign alu_op2_o    = beat_q.src_b ? beat_q.imm : fwd_data[1];
  assign store_data_o = fwd_data[1];
  assign alu_ctrl_o   = beat_q.ctrl;
  assign pc_o         = beat_q.pc;
  assign rd_addr_o    = beat_q.rd;
  assign reg_write_o  = beat_q.rw && valid_q;
  assign mem_read_o   = beat_q.mr && valid_q;
  assign mem_write_o  = beat_q.mw && valid_q;
endmodule

// File: tb/tb_idex_operand_stage.sv
// Directed bench for idex_operand_stage: reset, forwarding priority, x0,
// operand source select, load-use bubble, stall refresh, flush, async reset.
module tb_idex_operand_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid_i, in_ready_o;
  logic [DW-1:0] rs1_data_i, rs2_data_i, imm_i, pc_i;
  logic [AW-1:0] rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [2:0]    alu_ctrl_i;
  logic          alusrc_a_i, alusrc_b_i, reg_write_i, mem_read_i, mem_write_i, flush_i;
  logic [AW-1:0] exmem_rd_i, memwb_rd_i;
  logic          exmem_regwrite_i, memwb_regwrite_i;
  logic [DW-1:0] exmem_result_i, memwb_result_i;
  logic          out_ready_i, out_valid_o;
  logic [DW-1:0] alu_op1_o, alu_op2_o, store_data_o, pc_o;
  logic [2:0]    alu_ctrl_o;
  logic [AW-1:0] rd_addr_o;
  logic          reg_write_o, mem_read_o, mem_write_o;

  int n_vec = 0;
  int n_err = 0;

  idex_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .pc_i(pc_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .alu_ctrl_i(alu_ctrl_i), .alusrc_a_i(alusrc_a_i), .alusrc_b_i(alusrc_b_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_regwrite_i(exmem_regwrite_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_regwrite_i(memwb_regwrite_i), .memwb_result_i(memwb_result_i),
    .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
    .alu_op1_o(alu_op1_o), .alu_op2_o(alu_op2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .pc_o(pc_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] ra1, input logic [DW-1:0] d1,
                      input logic [AW-1:0] ra2, input logic [DW-1:0] d2,
                      input logic [AW-1:0] rd, input logic [2:0] ctrl,
                      input logic rw, input logic mr, input logic mw);
    in_valid_i  = 1'b1;
    rs1_addr_i  = ra1; rs1_data_i = d1;
    rs2_addr_i  = ra2; rs2_data_i = d2;
    rd_addr_i   = rd;  alu_ctrl_i = ctrl;
    reg_write_i = rw;  mem_read_i = mr; mem_write_i = mw;
    alusrc_a_i  = 1'b0; alusrc_b_i = 1'b0;
    pc_i = 32'h0; imm_i = 32'h0;
  endtask

  task automatic no_fwd();
    exmem_rd_i = '0; exmem_regwrite_i = 1'b0; exmem_result_i = '0;
    memwb_rd_i = '0; memwb_regwrite_i = 1'b0; memwb_result_i = '0;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    beat(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    no_fwd();
    #12;
    // Reset state
    chk("rst_valid", out_valid_o, 0);
    chk("rst_op1", alu_op1_o, 0);
    chk("rst_op2", alu_op2_o, 0);
    chk("rst_ctrl", alu_ctrl_o, 0);
    chk("rst_store", store_data_o, 0);
    chk("rst_pc", pc_o, 0);
    chk("rst_rd", rd_addr_o, 0);
    chk("rst_ctl", {reg_write_o, mem_read_o, mem_write_o}, 0);
    chk("rst_ready", in_ready_o, 1);
    @(negedge clk); rst_n = 1'b1;

    // ADD x3,x1,x2 with both forwarding paths hitting rs1
    step();
    beat(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    in_valid_i = 1'b0;
    exmem_rd_i = 5'd1; exmem_regwrite_i = 1'b1; exmem_result_i = 32'd100;
    memwb_rd_i = 5'd1; memwb_regwrite_i = 1'b1; memwb_result_i = 32'd50;
    #1;
    chk("add_valid", out_valid_o, 1);
    chk("add_op1_exmem", alu_op1_o, 100);
    chk("add_op2", alu_op2_o, 7);
    chk("add_rd", rd_addr_o, 3);
    chk("add_rw", reg_write_o, 1);
    exmem_regwrite_i = 1'b0; #1;
    chk("add_op1_memwb", alu_op1_o, 50);
    memwb_regwrite_i = 1'b0; #1;
    chk("add_op1_reg", alu_op1_o, 5);
    step();
    chk("drain_valid", out_valid_o, 0);
    chk("drain_rw", reg_write_o, 0);

    // x0 never forwarded; alusrc select and ctrl pass-through of 7
    beat(5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 3'd7, 1'b0, 1'b0, 1'b0);
    pc_i = 32'h1000; imm_i = 32'h44;
    exmem_rd_i = 5'd0; exmem_regwrite_i = 1'b1; exmem_result_i = 32'hFFFF;
    step();
    in_valid_i = 1'b0; #1;
    chk("x0_op1", alu_op1_o, 0);
    chk("x0_op2", alu_op2_o, 0);
    chk("ctrl7", alu_ctrl_o, 7);
    chk("pc_pass", pc_o, 32'h1000);
    no_fwd();
    beat(5'd1, 32'd9, 5'd2, 32'd8, 5'd1, 3'd5, 1'b1, 1'b0, 1'b0);
    alusrc_a_i = 1'b1; alusrc_b_i = 1'b1; pc_i = 32'h2000; imm_i = 32'h44;
    step();
    in_valid_i = 1'b0; #1;
    chk("srca_pc", alu_op1_o, 32'h2000);
    chk("srcb_imm", alu_op2_o, 32'h44);
    chk("store_rs2", store_data_o, 8);

    // Load-use: LW x4 held, next beat reads x4
    beat(5'd5, 32'h0, 5'd6, 32'h0, 5'd4, 3'd0, 1'b1, 1'b1, 1'b0);
    step();
    beat(5'd4, 32'h33, 5'd0, 32'h0, 5'd7, 3'd1, 1'b1, 1'b0, 1'b0);
    #1;
    chk("lu_mr", mem_read_o, 1);
    chk("lu_stall_ready", in_ready_o, 0);
    step();
    chk("lu_bubble_valid", out_valid_o, 0);
    chk("lu_bubble_mr", mem_read_o, 0);
    chk("lu_ready_again", in_ready_o, 1);
    step();
    in_valid_i = 1'b0; #1;
    chk("lu_accept_valid", out_valid_o, 1);
    chk("lu_accept_rd", rd_addr_o, 7);
    chk("lu_accept_op1", alu_op1_o, 32'h33);

    // Stall 3 cycles with MEM/WB producer of x2 vanishing after the first
    beat(5'd0, 32'h0, 5'd2, 32'h11, 5'd6, 3'd0, 1'b1, 1'b0, 1'b0);
    step();
    beat(5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 3'd2, 1'b1, 1'b0, 1'b1);
    out_ready_i = 1'b0;
    memwb_rd_i = 5'd2; memwb_regwrite_i = 1'b1; memwb_result_i = 32'hAB;
    #1;
    chk("st_op2_fwd", alu_op2_o, 32'hAB);
    chk("st_ready", in_ready_o, 0);
    step();
    no_fwd(); #1;
    chk("st_op2_c1", alu_op2_o, 32'hAB);
    chk("st_store_c1", store_data_o, 32'hAB);
    chk("st_rd_c1", rd_addr_o, 6);
    step();
    chk("st_op2_c2", alu_op2_o, 32'hAB);
    step();
    chk("st_op2_c3", alu_op2_o, 32'hAB);
    chk("st_rd_c3", rd_addr_o, 6);
    chk("st_valid_c3", out_valid_o, 1);
    out_ready_i = 1'b1; #1;
    chk("st_release_ready", in_ready_o, 1);
    step();
    chk("st_next_rd", rd_addr_o, 9);
    chk("st_next_mw", mem_write_o, 1);

    // Flush with a firing beat: held store killed, new beat discarded
    beat(5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 3'd0, 1'b1, 1'b0, 1'b1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0; in_valid_i = 1'b0; #1;
    chk("fl_valid", out_valid_o, 0);
    chk("fl_rw", reg_write_o, 0);
    chk("fl_mw", mem_write_o, 0);
    chk("fl_rd_kept", rd_addr_o, 9);

    // Async reset while stalled
    beat(5'd1, 32'h55, 5'd2, 32'h66, 5'd11, 3'd3, 1'b1, 1'b0, 1'b0);
    step();
    in_valid_i = 1'b0; out_ready_i = 1'b0; #2;
    chk("ar_pre_valid", out_valid_o, 1);
    rst_n = 1'b0; #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_op1", alu_op1_o, 0);
    chk("ar_op2", alu_op2_o, 0);
    chk("ar_ctrl", alu_ctrl_o, 0);
    chk("ar_rd", rd_addr_o, 0);
    chk("ar_rw", reg_write_o, 0);
    @(negedge clk); rst_n = 1'b1; out_ready_i = 1'b1;
    beat(5'd1, 32'h77, 5'd0, 32'h0, 5'd12, 3'd4, 1'b1, 1'b0, 1'b0);
    #1;
    chk("ar_post_pre", out_valid_o, 0);
    step();
    in_valid_i = 1'b0; #1;
    chk("ar_post_valid", out_valid_o, 1);
    chk("ar_post_rd", rd_addr_o, 12);
    chk("ar_post_op1", alu_op1_o, 32'h77);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
